// File: rtl/bus_mem.sv
// 6502 bus memory model: registered read, optional wait states, write-protected ROM window,
// open-bus reads beyond DEPTH, and a FILL sweep of the RAM region after every reset.
module bus_mem #(
    parameter int            AW        = 16,
    parameter int            DW        = 8,
    parameter int            DEPTH     = 65536,
    parameter int            ROM_BASE  = 49152,
    parameter int            WAIT      = 0,
    parameter logic [DW-1:0] FILL      = '0,
    parameter logic [DW-1:0] OPEN_BUS  = '1,
    parameter                INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] ab,
    input  logic          we,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] rd,
    output logic          rdy,
    output logic          busy,
    output logic          wp_hit
);

    localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] CLR_LAST = IW'(ROM_BASE - 1);
    localparam logic [3:0]    WAIT_L   = 4'(WAIT);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAITS, S_ACK} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] clr_addr_q, clr_addr_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] rd_q, rd_d;
    logic          rdy_q, rdy_d;
    logic          busy_q, busy_d;
    logic          wp_hit_q, wp_hit_d;
    logic [AW-1:0] lat_ab_q, lat_ab_d;
    logic          lat_we_q, lat_we_d;
    logic [DW-1:0] lat_wd_q, lat_wd_d;

    logic [DW-1:0] mem [DEPTH];

    logic          mem_we;
    logic [IW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic          acc_go;
    logic [AW-1:0] acc_ab;
    logic          acc_we;
    logic [DW-1:0] acc_wd;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wait_cnt_d = wait_cnt_q;
        rd_d       = rd_q;
        rdy_d      = rdy_q;
        busy_d     = busy_q;
        wp_hit_d   = 1'b0;
        lat_ab_d   = lat_ab_q;
        lat_we_d   = lat_we_q;
        lat_wd_d   = lat_wd_q;
        mem_we     = 1'b0;
        mem_wa     = clr_addr_q;
        mem_wd     = FILL;
        acc_go     = 1'b0;
        acc_ab     = ab;
        acc_we     = we;
        acc_wd     = wd;

        case (state_q)
            S_CLEAR: begin
                if (ROM_BASE == 0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    rdy_d   = (WAIT == 0);
                end else begin
                    mem_we     = 1'b1;
                    clr_addr_d = clr_addr_q + 1'b1;
                    if (clr_addr_q == CLR_LAST) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        rdy_d   = (WAIT == 0);
                    end
                end
            end
            S_IDLE: begin
                if (WAIT == 0) begin
                    acc_go = 1'b1;
                end else begin
                    lat_ab_d   = ab;
                    lat_we_d   = we;
                    lat_wd_d   = wd;
                    wait_cnt_d = WAIT_L;
                    state_d    = S_WAITS;
                    rdy_d      = 1'b0;
                end
            end
            S_WAITS: begin
                acc_ab     = lat_ab_q;
                acc_we     = lat_we_q;
                acc_wd     = lat_wd_q;
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    acc_go  = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                rdy_d   = 1'b0;
            end
            default: state_d = S_CLEAR;
        endcase

        // ROM_BASE <= DEPTH, so the writable test also rejects out-of-range targets
        if (acc_go) begin
            if (acc_we) begin
                if (32'(acc_ab) < ROM_BASE) begin
                    mem_we = 1'b1;
                    mem_wa = acc_ab[IW-1:0];
                    mem_wd = acc_wd;
                end else begin
                    wp_hit_d = 1'b1;
                end
            end else begin
                rd_d = (32'(acc_ab) < DEPTH) ? mem[acc_ab[IW-1:0]] : OPEN_BUS;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            wait_cnt_q <= '0;
            rd_q       <= '0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b1;
            wp_hit_q   <= 1'b0;
            lat_ab_q   <= '0;
            lat_we_q   <= 1'b0;
            lat_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wait_cnt_q <= wait_cnt_d;
            rd_q       <= rd_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            wp_hit_q   <= wp_hit_d;
            lat_ab_q   <= lat_ab_d;
            lat_we_q   <= lat_we_d;
            lat_wd_q   <= lat_wd_d;
        end
    end

    // While reset is held this rewrites FILL into word 0, which the sweep does anyway on release.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign rd     = rd_q;
    assign rdy    = rdy_q;
    assign busy   = busy_q;
    assign wp_hit = wp_hit_q;

endmodule

// File: tb/tb_bus_mem.sv
// Directed bench for bus_mem: three instances (WAIT=0, WAIT=2, WAIT=3) sharing clk and reset.
module tb_bus_mem;

    logic       clk = 1'b0;
    logic       reset;
    logic [15:0] ab0, ab2, ab3;
    logic        we0, we2, we3;
    logic [7:0]  wd0, wd2, wd3;
    logic [7:0]  rd0, rd2, rd3;
    logic        rdy0, rdy2, rdy3;
    logic        busy0, busy2, busy3;
    logic        wp0, wp2, wp3;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bus_mem #(.AW(16), .DW(8), .DEPTH(28), .ROM_BASE(16), .WAIT(0), .FILL(8'h00), .OPEN_BUS(8'hFF)) u0 (
        .clk(clk), .reset(reset), .ab(ab0), .we(we0), .wd(wd0),
        .rd(rd0), .rdy(rdy0), .busy(busy0), .wp_hit(wp0));

    bus_mem #(.AW(16), .DW(8), .DEPTH(28), .ROM_BASE(16), .WAIT(2), .FILL(8'h00), .OPEN_BUS(8'hFF)) u2 (
        .clk(clk), .reset(reset), .ab(ab2), .we(we2), .wd(wd2),
        .rd(rd2), .rdy(rdy2), .busy(busy2), .wp_hit(wp2));

    bus_mem #(.AW(16), .DW(8), .DEPTH(28), .ROM_BASE(16), .WAIT(3), .FILL(8'h3C), .OPEN_BUS(8'hFF)) u3 (
        .clk(clk), .reset(reset), .ab(ab3), .we(we3), .wd(wd3),
        .rd(rd3), .rdy(rdy3), .busy(busy3), .wp_hit(wp3));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        reset = 1'b1;
        ab0 = '0; we0 = 1'b0; wd0 = '0;
        ab2 = '0; we2 = 1'b0; wd2 = '0;
        ab3 = '0; we3 = 1'b0; wd3 = '0;

        // Stand-in for an init image: A9 across RAM, C0+addr across ROM, 11 at 23
        for (int i = 0; i < 28; i++) begin
            v = (i >= 16) ? 8'(8'hC0 + i) : 8'hA9;
            if (i == 23) v = 8'h11;
            u0.mem[i] = v;
            u2.mem[i] = v;
            u3.mem[i] = v;
        end

        step();
        step();
        chk("rst_rd0", rd0, 8'h00);
        chk("rst_rdy0", rdy0, 1'b0);
        chk("rst_busy0", busy0, 1'b1);
        chk("rst_wp0", wp0, 1'b0);
        chk("rst_rdy2", rdy2, 1'b0);
        chk("rst_busy3", busy3, 1'b1);

        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("clr_busy0", busy0, 1'b1);
            step();
        end
        chk("clr_done0", busy0, 1'b0);
        chk("clr_done2", busy2, 1'b0);
        chk("clr_done3", busy3, 1'b0);
        chk("idle_rdy0", rdy0, 1'b1);

        // WAIT=0: single-cycle registered accesses
        ab0 = 16'd0; step();
        chk("rd0_a0_cleared", rd0, 8'h00);
        ab0 = 16'd1; we0 = 1'b1; wd0 = 8'h14; step();
        chk("wr0_a1_wp", wp0, 1'b0);
        chk("wr0_a1_rdhold", rd0, 8'h00);
        we0 = 1'b0; step();
        chk("rd0_a1", rd0, 8'h14);
        chk("rd0_a1_rdy", rdy0, 1'b1);
        ab0 = 16'd23; step();
        chk("rd0_a23_rom", rd0, 8'h11);
        ab0 = 16'd16; step();
        chk("rd0_a16_rombase", rd0, 8'hD0);
        ab0 = 16'd20; we0 = 1'b1; wd0 = 8'hAA; step();
        chk("wr0_rom_wp", wp0, 1'b1);
        chk("wr0_rom_rdhold", rd0, 8'hD0);
        we0 = 1'b0; step();
        chk("wr0_rom_wp_end", wp0, 1'b0);
        chk("rd0_a20_unchanged", rd0, 8'hD4);
        ab0 = 16'd40; we0 = 1'b1; step();
        chk("wr0_oor_wp", wp0, 1'b1);
        we0 = 1'b0; step();
        chk("wr0_oor_wp_end", wp0, 1'b0);
        chk("rd0_a40_openbus", rd0, 8'hFF);
        ab0 = 16'd15; we0 = 1'b1; wd0 = 8'h77; step();
        chk("wr0_a15_lastram", wp0, 1'b0);
        we0 = 1'b0; step();
        chk("rd0_a15", rd0, 8'h77);
        ab0 = 16'd27; step();
        chk("rd0_a27_lastword", rd0, 8'hDB);
        ab0 = 16'd28; step();
        chk("rd0_a28_depth", rd0, 8'hFF);

        // WAIT=2: align on an ACK cycle, then present the next access
        for (int i = 0; i < 20 && rdy2 !== 1'b1; i++) step();
        chk("sync2", rdy2, 1'b1);
        chk("idle2_rd", rd2, 8'h00);
        ab2 = 16'd3; we2 = 1'b1; wd2 = 8'h5A;
        step(); chk("w2_ack_to_idle", rdy2, 1'b0);
        step(); chk("w2_wait_a", rdy2, 1'b0);
        step(); chk("w2_wait_b", rdy2, 1'b0);
        step(); chk("w2_done_rdy", rdy2, 1'b1);
        chk("w2_done_wp", wp2, 1'b0);
        chk("w2_rdhold", rd2, 8'h00);
        we2 = 1'b0;
        step(); chk("r2_ack_to_idle", rdy2, 1'b0);
        step(); chk("r2_wait_a", rdy2, 1'b0);
        step(); chk("r2_wait_b", rdy2, 1'b0);
        step(); chk("r2_done_rdy", rdy2, 1'b1);
        chk("r2_a3", rd2, 8'h5A);
        ab2 = 16'd20; we2 = 1'b1; wd2 = 8'hAA;
        step(); chk("wrom2_idle_wp", wp2, 1'b0);
        step(); chk("wrom2_wait_a_wp", wp2, 1'b0);
        step(); chk("wrom2_wait_b_wp", wp2, 1'b0);
        step(); chk("wrom2_done_wp", wp2, 1'b1);
        chk("wrom2_done_rdy", rdy2, 1'b1);
        we2 = 1'b0;
        step(); chk("wrom2_ack_wp", wp2, 1'b0);
        chk("wrom2_ack_rdy", rdy2, 1'b0);
        step(); step(); step();
        chk("r2_a20_unchanged", rd2, 8'hD4);
        chk("r2_a20_rdy", rdy2, 1'b1);

        // WAIT=3: reset lands while a write is waiting
        for (int i = 0; i < 20 && rdy3 !== 1'b1; i++) step();
        chk("sync3", rdy3, 1'b1);
        ab3 = 16'd5; we3 = 1'b1; wd3 = 8'h66;
        step(); step(); step();
        chk("w3_in_waits", rdy3, 1'b0);
        reset = 1'b1;
        #1;
        chk("w3_rst_busy", busy3, 1'b1);
        chk("w3_rst_rdy", rdy3, 1'b0);
        chk("w3_rst_wp", wp3, 1'b0);
        step();
        we3 = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("w3_clr_busy", busy3, 1'b1);
            step();
        end
        chk("w3_clr_done", busy3, 1'b0);
        for (int i = 0; i < 20 && rdy3 !== 1'b1; i++) step();
        chk("sync3_post", rdy3, 1'b1);
        chk("r3_a5_fill", rd3, 8'h3C);

        // Reset in the middle of the clear sweep restarts it from address 0
        ab0 = 16'd1; we0 = 1'b0;
        reset = 1'b1; step(); reset = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("mid_clr_busy", busy0, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("reclr_busy0", busy0, 1'b1);
            step();
        end
        chk("reclr_done0", busy0, 1'b0);
        step();
        chk("reclr_a1_cleared", rd0, 8'h00);
        ab0 = 16'd23; step();
        chk("reclr_a23_kept", rd0, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
